hamming21_decode_sched: RTL and testbench
=========================================

Name: hamming21_decode_sched

Overview:
- Shared, bit-serial Hamming(21,16) SEC decode engine with a round-robin front end for NUM_REQ codeword requesters.
- Each granted codeword is scanned one bit per cycle to accumulate the 5-bit syndrome. The single erroneous bit is then corrected, and the 16 data bits are returned with a valid/ready handshake tagged by requester ID.
- Sits between the link-side requesters and the consumers of decoded data, replacing free-running, unsequenced use of the serial decoder.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- ID_W, $clog2(NUM_REQ) min 1, requester ID width.

Ports:
- clk  in  1  clock; all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester codeword valid.
- req_code  in  NUM_REQ*21  codewords; requester i occupies [21*i+20:21*i].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  16  corrected data.
- out_syn  out  5  final syndrome.
- out_id  out  ID_W  originating requester.
- out_corr  out  1  syndrome in 1..21, one bit flipped.
- out_uncorr  out  1  syndrome in 22..31, data passed uncorrected.

Behaviour:
- Codeword bit e[k-1] is position k (1..21).
- Parity bits sit at positions 1, 2, 4, 8 and 16.
- Data bits sit at the remaining positions in ascending order: out_data[0] is position 3, [1] is 5, [2] is 6, [3] is 7, [4..10] are 9..15, [11..15] are 17..21.
- Reset: state=IDLE, rr pointer=NUM_REQ-1 (so requester 0 wins first), req_ready=0, out_valid=0, out_data=0, out_syn=0, out_id=0, out_corr=0, out_uncorr=0, bit counter=0.
- IDLE:
  - req_ready is the one-hot round-robin grant over req_valid; priority starts at pointer+1 and wraps.
  - Accept happens when req_ready[g]&&req_valid[g]. That cycle the codeword is latched into a shift register, id=g, syn=0, cnt=1, pointer=g, and the state goes to SHIFT.
  - req_ready is 0 in every state other than IDLE.
- SHIFT:
  - Each cycle, if shift_reg[0]==1 then syn ^= cnt[4:0].
  - The bit is rotated back into the register, and cnt increments.
  - After cnt==21 is processed (21 cycles), go to CORRECT.
- CORRECT (1 cycle):
  - syn==0: no flags.
  - 1..21: flip position syn, out_corr=1.
  - 22..31: no flip, out_uncorr=1.
  - Extract the data bits, register all outputs, set out_valid=1, go to OUT.
- OUT:
  - Outputs are held stable while out_valid&&!out_ready.
  - On out_ready: out_valid=0 and go to IDLE. The next accept occurs in the IDLE cycle that follows, with no bypass.
- Latency: out_valid rises 23 cycles after the accept edge. Throughput is 1 codeword per 24+ cycles.
- req_valid deasserting before grant: no accept and no side effects.
- req_valid changes during SHIFT, CORRECT or OUT are ignored.
- rst_n low at any point, including mid-SHIFT, immediately returns every output to its reset value. The in-flight word is dropped and never produced.
- NUM_REQ=1: the arbiter degenerates to req_ready[0]=IDLE.

Optional Feature:
- Macro HAMMING_ERR_CNT_EN.
- Defined:
  - Adds outputs cnt_corr[15:0] and cnt_uncorr[15:0], plus input cnt_clr.
  - Each counter increments by 1 on the out_valid&&out_ready handshake of a result carrying its flag.
  - Counters saturate at 16'hFFFF.
  - cnt_clr is synchronous, zeroes both counters and wins over a simultaneous increment.
  - Counters reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package hamming21_pkg:
  - CW_W=21, DATA_W=16, SYN_W=5.
  - PARITY_POS mask 21'h008_08B (positions 1, 2, 4, 8, 16).
  - State enum {IDLE, SHIFT, CORRECT, OUT}.
  - Data-extraction function.
- Sub-module rr_arbiter (NUM_REQ, rotating priority, one-hot grant, pointer update on accept).

Test Plan:
- Requester 0 sends 21'h000007 (data 16'h0001, clean) -> 23 cycles later out_valid=1, out_data=16'h0001, out_syn=0, out_corr=0, out_uncorr=0, out_id=0.
- Requester 0 sends 21'h000010 (all-zero word, position 5 flipped) -> out_syn=5, out_corr=1, out_data=16'h0000.
- Requester 1 sends 21'h008020 (positions 6 and 16 set) -> out_syn=22, out_uncorr=1, out_data=16'h0004, out_id=1.
- Both requesters hold req_valid from reset with distinct words -> requester 0 is served first, then requester 1, then requester 0. req_ready is one-hot and is only asserted in IDLE.
- Hold out_ready=0 for 10 cycles once out_valid rises -> all outputs stay stable and no new req_ready is asserted. Then pulse out_ready -> out_valid drops the next cycle.
- Assert rst_n=0 at SHIFT cycle 10, release, then send 21'h000007 -> no stale out_valid appears, and the clean result returns 23 cycles after the new accept. With HAMMING_ERR_CNT_EN defined, cnt_corr and cnt_uncorr match the flag tally after the scenarios above (1 and 1).

Source files
------------

// File: rtl/hamming21_pkg.sv
// Shared constants, FSM encoding and data-extraction helper for the serial Hamming(21,16) decoder.
package hamming21_pkg;

  localparam int CW_W   = 21;
  localparam int DATA_W = 16;
  localparam int SYN_W  = 5;

  // Positions 1, 2, 4, 8, 16 (bit k-1 holds position k).
  localparam logic [CW_W-1:0] PARITY_POS = 21'h00808B;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CORRECT,
    OUT
  } state_t;

  // Data bits occupy the non-parity positions in ascending order.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    return {cw[20:16], cw[14:8], cw[6:4], cw[2]};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority one-hot arbiter; search starts one past the last winner.
// Combinational grant, pointer advances only on an accepted grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               accept
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic            found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
    accept = en && found;
    if (accept) grant[grant_id] = 1'b1;
    ptr_d = accept ? grant_id : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= ID_W'(NUM_REQ - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hamming21_decode_sched.sv
// Shared bit-serial Hamming(21,16) SEC decoder behind a round-robin front end; result 23 cycles
// after the accept cycle, held until out_ready. Optional error counters via HAMMING_ERR_CNT_EN.
module hamming21_decode_sched
  import hamming21_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*CW_W-1:0] req_code,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [SYN_W-1:0]        out_syn,
  output logic [ID_W-1:0]         out_id,
  output logic                    out_corr,
  output logic                    out_uncorr
`ifdef HAMMING_ERR_CNT_EN
  ,
  input  logic                    cnt_clr,
  output logic [15:0]             cnt_corr,
  output logic [15:0]             cnt_uncorr
`endif
);

  state_t            state_q, state_d;
  logic [CW_W-1:0]   shift_q, shift_d;
  logic [SYN_W-1:0]  syn_q, syn_d;
  logic [SYN_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SYN_W-1:0]  out_syn_q, out_syn_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_corr_q, out_corr_d;
  logic              out_uncorr_q, out_uncorr_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               arb_accept;
  logic               arb_en;
  logic [CW_W-1:0]    sel_code;
  logic [CW_W-1:0]    flip_mask;
  logic               syn_corr;
  logic               syn_uncorr;

  // Gating with rst_n keeps req_ready low while reset is held.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (arb_en),
    .req     (req_valid),
    .grant   (grant),
    .grant_id(grant_id),
    .accept  (arb_accept)
  );

  always_comb begin
    sel_code = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_code = req_code[i*CW_W +: CW_W];
    end
  end

  assign syn_corr   = (syn_q >= SYN_W'(1)) && (syn_q <= SYN_W'(CW_W));
  assign syn_uncorr = (syn_q > SYN_W'(CW_W));
  assign flip_mask  = CW_W'(1) << (syn_q - SYN_W'(1));

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    syn_d        = syn_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_syn_d    = out_syn_q;
    out_id_d     = out_id_q;
    out_corr_d   = out_corr_q;
    out_uncorr_d = out_uncorr_q;
    case (state_q)
      IDLE: begin
        if (arb_accept) begin
          shift_d = sel_code;
          id_d    = grant_id;
          syn_d   = '0;
          cnt_d   = SYN_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Rotate so the codeword is intact again after 21 steps.
        if (shift_q[0]) syn_d = syn_q ^ cnt_q;
        shift_d = {shift_q[0], shift_q[CW_W-1:1]};
        cnt_d   = cnt_q + SYN_W'(1);
        if (cnt_q == SYN_W'(CW_W)) state_d = CORRECT;
      end
      CORRECT: begin
        out_data_d   = extract_data(syn_corr ? (shift_q ^ flip_mask) : shift_q);
        out_syn_d    = syn_q;
        out_id_d     = id_q;
        out_corr_d   = syn_corr;
        out_uncorr_d = syn_uncorr;
        out_valid_d  = 1'b1;
        state_d      = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      syn_q        <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_id_q     <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      syn_q        <= syn_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_syn_q    <= out_syn_d;
      out_id_q     <= out_id_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
    end
  end

  assign req_ready  = grant;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_syn    = out_syn_q;
  assign out_id     = out_id_q;
  assign out_corr   = out_corr_q;
  assign out_uncorr = out_uncorr_q;

`ifdef HAMMING_ERR_CNT_EN
  logic [15:0] cnt_corr_q, cnt_corr_d;
  logic [15:0] cnt_uncorr_q, cnt_uncorr_d;
  logic        out_hs;

  assign out_hs = out_valid_q && out_ready;

  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (cnt_clr) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (out_hs) begin
      if (out_corr_q && (cnt_corr_q != 16'hFFFF))     cnt_corr_d   = cnt_corr_q + 16'd1;
      if (out_uncorr_q && (cnt_uncorr_q != 16'hFFFF)) cnt_uncorr_d = cnt_uncorr_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;
`endif

endmodule

// File: tb/tb_hamming21_decode_sched.sv
// Self-checking bench for hamming21_decode_sched: directed table, multi-cycle corner cases,
// and randomized codewords checked against a position-arithmetic reference decoder.
module tb_hamming21_decode_sched;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*21-1:0] req_code;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          out_data;
  logic [4:0]           out_syn;
  logic [ID_W-1:0]      out_id;
  logic                 out_corr;
  logic                 out_uncorr;
`ifdef HAMMING_ERR_CNT_EN
  logic                 cnt_clr;
  logic [15:0]          cnt_corr;
  logic [15:0]          cnt_uncorr;
`endif

  hamming21_decode_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_syn   (out_syn),
    .out_id    (out_id),
    .out_corr  (out_corr),
    .out_uncorr(out_uncorr)
`ifdef HAMMING_ERR_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .cnt_corr  (cnt_corr),
    .cnt_uncorr(cnt_uncorr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] data;
    logic [4:0]  syn;
    logic        corr;
    logic        uncorr;
  } res_t;

  function automatic bit is_pow2(input int k);
    return (k & (k - 1)) == 0;
  endfunction

  function automatic logic [4:0] syndrome(input logic [20:0] cw);
    logic [4:0] s;
    s = '0;
    for (int k = 1; k <= 21; k++) if (cw[k-1]) s ^= 5'(k);
    return s;
  endfunction

  function automatic res_t model(input logic [20:0] cw);
    res_t r;
    logic [20:0] c;
    int j;
    int p;
    c = cw;
    r.syn    = syndrome(cw);
    p        = int'(r.syn);
    r.corr   = (p >= 1) && (p <= 21);
    r.uncorr = (p >= 22);
    if (r.corr) c[p-1] = ~c[p-1];
    r.data = '0;
    j = 0;
    for (int k = 1; k <= 21; k++) begin
      if (!is_pow2(k)) begin
        r.data[j] = c[k-1];
        j++;
      end
    end
    return r;
  endfunction

  function automatic logic [20:0] encode(input logic [15:0] d);
    logic [20:0] cw;
    logic [4:0]  s;
    int j;
    cw = '0;
    j  = 0;
    for (int k = 1; k <= 21; k++) begin
      if (!is_pow2(k)) begin
        cw[k-1] = d[j];
        j++;
      end
    end
    s = syndrome(cw);
    for (int b = 0; b < 5; b++) if (s[b]) cw[(1 << b) - 1] = 1'b1;
    return cw;
  endfunction

  // ---------------- one transaction ----------------
  task automatic run_one(input string tag, input int r, input logic [20:0] code,
                         input logic [15:0] e_data, input logic [4:0] e_syn,
                         input logic e_corr, input logic e_uncorr, input int hold);
    int n;
    int lat;
    bit ok;
    logic [15:0] s_data;
    logic [4:0]  s_syn;
    logic [ID_W-1:0] s_id;
    logic s_corr, s_uncorr;
    req_code[21*r +: 21] = code;
    req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[r] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready[r]) begin
      chk({tag, "_grant_timeout"}, 32'(req_ready), 32'(1 << r));
      req_valid[r] = 1'b0;
      return;
    end
    chk({tag, "_ready_onehot"}, 32'(req_ready), 32'(1 << r));
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    lat = 0;
    ok  = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready != '0) ok = 1'b0;
    end while (!out_valid && lat < 60);
    chk({tag, "_latency"}, 32'(lat), 32'd23);
    chk({tag, "_no_ready_busy"}, 32'(ok), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(e_data));
    chk({tag, "_syn"}, 32'(out_syn), 32'(e_syn));
    chk({tag, "_id"}, 32'(out_id), 32'(r));
    chk({tag, "_corr"}, 32'(out_corr), 32'(e_corr));
    chk({tag, "_uncorr"}, 32'(out_uncorr), 32'(e_uncorr));
    if (hold > 0) begin
      s_data = out_data; s_syn = out_syn; s_id = out_id;
      s_corr = out_corr; s_uncorr = out_uncorr;
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!out_valid || out_data !== s_data || out_syn !== s_syn || out_id !== s_id ||
            out_corr !== s_corr || out_uncorr !== s_uncorr || req_ready != '0) ok = 1'b0;
      end
      chk({tag, "_hold_stable"}, 32'(ok), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_syn"}, 32'(out_syn), 32'd0);
    chk({tag, "_out_id"}, 32'(out_id), 32'd0);
    chk({tag, "_flags"}, 32'({out_corr, out_uncorr}), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  typedef struct {
    int          r;
    logic [20:0] code;
    logic [15:0] data;
    logic [4:0]  syn;
    logic        corr;
    logic        uncorr;
    int          hold;
  } vec_t;

  vec_t tbl[3];

  initial begin
    int grants[$];
    int ids[$];
    bit onehot_ok;
    bit excl_ok;
    int n;
    bit ok;
    tbl[0] = '{0, 21'h000007, 16'h0001, 5'd0,  1'b0, 1'b0, 10};
    tbl[1] = '{0, 21'h000010, 16'h0000, 5'd5,  1'b1, 1'b0, 0};
    tbl[2] = '{1, 21'h008020, 16'h0004, 5'd22, 1'b0, 1'b1, 2};

    rst_n     = 1'b0;
    req_valid = '0;
    req_code  = '0;
    out_ready = 1'b0;
`ifdef HAMMING_ERR_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    check_reset_outputs("reset");
`ifdef HAMMING_ERR_CNT_EN
    chk("reset_cnt", 32'({cnt_corr, cnt_uncorr}), 32'd0);
`endif
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 3; i++)
      run_one($sformatf("vec%0d", i), tbl[i].r, tbl[i].code, tbl[i].data, tbl[i].syn,
              tbl[i].corr, tbl[i].uncorr, tbl[i].hold);

`ifdef HAMMING_ERR_CNT_EN
    @(negedge clk);
    chk("cnt_corr_tally", 32'(cnt_corr), 32'd1);
    chk("cnt_uncorr_tally", 32'(cnt_uncorr), 32'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_clr", 32'({cnt_corr, cnt_uncorr}), 32'd0);
`endif

    // Both requesters contend from reset: expect 0, 1, 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    req_code  = {21'h000010, 21'h000007};
    req_valid = 2'b11;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    onehot_ok = 1'b1;
    excl_ok   = 1'b1;
    n = 0;
    while (ids.size() < 3 && n < 200) begin
      #1;
      if (req_ready != '0) begin
        if ($countones(req_ready) != 1) onehot_ok = 1'b0;
        grants.push_back(req_ready[1] ? 1 : 0);
      end
      if (out_valid) begin
        ids.push_back(int'(out_id));
        if (req_ready != '0) excl_ok = 1'b0;
      end
      if (ids.size() < 3) begin
        @(negedge clk);
        n++;
      end
    end
    req_valid = '0;
    chk("fair_results", 32'(ids.size()), 32'd3);
    chk("fair_grants", 32'(grants.size()), 32'd3);
    chk("fair_onehot", 32'(onehot_ok), 32'd1);
    chk("fair_ready_idle_only", 32'(excl_ok), 32'd1);
    if (ids.size() == 3) begin
      chk("fair_id0", 32'(ids[0]), 32'd0);
      chk("fair_id1", 32'(ids[1]), 32'd1);
      chk("fair_id2", 32'(ids[2]), 32'd0);
    end
    if (grants.size() >= 3) chk("fair_grant_order", 32'({grants[0][3:0], grants[1][3:0], grants[2][3:0]}), 32'h010);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);

    // Reset during SHIFT drops the in-flight word.
    req_code[20:0] = 21'h000010;
    req_valid[0]   = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b0;
    end
    chk("midreset_no_stale", 32'(ok), 32'd1);
    run_one("post_reset", 0, 21'h000007, 16'h0001, 5'd0, 1'b0, 1'b0, 0);

    // Randomized codewords with 0..2 flipped bits.
    for (int t = 0; t < 40; t++) begin
      int r;
      logic [15:0] d;
      logic [20:0] cw;
      res_t e;
      r  = int'($urandom_range(0, NUM_REQ - 1));
      d  = 16'($urandom);
      cw = encode(d);
      for (int f = 0; f < int'($urandom_range(0, 2)); f++) cw[$urandom_range(0, 20)] ^= 1'b1;
      e = model(cw);
      run_one($sformatf("rnd%0d", t), r, cw, e.data, e.syn, e.corr, e.uncorr,
              int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
